// File: rtl/interruption_logic_pkg.sv
// Shared types and constants for the multi-channel interruption logic.
package interruption_logic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DEC  = 2'd2,
    REL  = 2'd3
  } ti_state_t;

  // All-ones pattern of the given width (up to 64 bits); used as the
  // "breakpoint disabled" marker.
  function automatic logic [63:0] bp_disable(input int unsigned width);
    return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/il_step_gen.sv
// Step-burst generator: edge-detects step_req and holds step_busy for
// max(step_len,1) cycles.
module il_step_gen
  import interruption_logic_pkg::*;
#(
  parameter int STEP_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_len,
  input  logic              decouple,
  output logic              step_busy
);

  logic              step_req_r_q, step_req_r_d;
  logic              step_req_rr_q, step_req_rr_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              step_busy_q, step_busy_d;
  logic              step_rise;

  always_comb begin
    step_req_r_d  = step_req;
    step_req_rr_d = step_req_r_q;
    step_cnt_d    = step_cnt_q;
    step_busy_d   = step_busy_q;
    step_rise     = step_req_r_q & ~step_req_rr_q;

    // Edges during a burst or while decoupled are dropped, not queued.
    if (step_busy_q) begin
      step_cnt_d = step_cnt_q - STEP_W'(1);
      if (step_cnt_q == STEP_W'(1)) step_busy_d = 1'b0;
    end else if (step_rise && !decouple) begin
      step_cnt_d  = (step_len == '0) ? STEP_W'(1) : step_len;
      step_busy_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      step_req_r_q  <= 1'b0;
      step_req_rr_q <= 1'b0;
      step_cnt_q    <= '0;
      step_busy_q   <= 1'b0;
    end else begin
      step_req_r_q  <= step_req_r_d;
      step_req_rr_q <= step_req_rr_d;
      step_cnt_q    <= step_cnt_d;
      step_busy_q   <= step_busy_d;
    end
  end

  assign step_busy = step_busy_q;

endmodule

// File: rtl/interruption_logic_mc.sv
// Multi-channel interruption logic: per-channel BUFGCE enables, event counter
// with breakpoint, step bursts and the stop_req/stop_ack/decouple handshake.
//
// state | meaning
// IDLE  | running normally, waiting for ti_req or breakpoint edge
// REQ   | stop_req asserted, waiting for every wrapper to ack
// DEC   | decoupled, waiting for pr_done edge
// REL   | stop_req dropped, waiting for all acks to clear
module interruption_logic_mc
  import interruption_logic_pkg::*;
#(
  parameter int NUM_TI_WRAPPERS = 1,
  parameter int NUM_CLK_CH      = 2,
  parameter int CNT_W           = 32,
  parameter int STEP_W          = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_reset_n,
  input  logic                       clk_en,
  input  logic                       step_req,
  input  logic [STEP_W-1:0]          step_len,
  input  logic [NUM_CLK_CH-1:0]      step_mask,
  input  logic [NUM_CLK_CH-1:0]      ch_mask,
  input  logic [CNT_W-1:0]           breakpoint,
  input  logic                       bp_clear,
  input  logic                       user_signal,
  input  logic                       ti_req,
  input  logic                       pr_done,
  output logic [NUM_CLK_CH-1:0]      clk_ce,
  output logic [NUM_TI_WRAPPERS-1:0] stop_req,
  input  logic [NUM_TI_WRAPPERS-1:0] stop_ack,
  output logic                       decouple,
  output logic [CNT_W-1:0]           event_cnt,
  output logic                       bp_hit,
  output logic                       step_busy,
  output logic [1:0]                 ti_state
);

  localparam logic [CNT_W-1:0] BP_DISABLE = CNT_W'(bp_disable(CNT_W));

  logic                       clk_en_r_q, clk_en_r_d;
  logic                       ti_req_r_q, ti_req_r_d;
  logic                       ti_req_rr_q, ti_req_rr_d;
  logic                       pr_done_r_q, pr_done_r_d;
  logic                       pr_done_rr_q, pr_done_rr_d;
  logic                       bp_hit_q, bp_hit_d;
  logic                       bp_hit_dly_q, bp_hit_dly_d;
  logic [CNT_W-1:0]           event_cnt_q, event_cnt_d;
  logic [NUM_CLK_CH-1:0]      clk_ce_q, clk_ce_d;
  logic [NUM_TI_WRAPPERS-1:0] stop_req_q, stop_req_d;
  logic                       decouple_q, decouple_d;
  ti_state_t                  state_q, state_d;

  logic run, active, bp_match, trigger, pr_rise, busy;

  il_step_gen #(.STEP_W(STEP_W)) u_step_gen (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .step_req    (step_req),
    .step_len    (step_len),
    .decouple    (decouple_q),
    .step_busy   (busy)
  );

  always_comb begin
    clk_en_r_d   = clk_en;
    ti_req_r_d   = ti_req;
    ti_req_rr_d  = ti_req_r_q;
    pr_done_r_d  = pr_done;
    pr_done_rr_d = pr_done_r_q;
    bp_hit_dly_d = bp_hit_q;

    run      = clk_en_r_q & ~bp_hit_q & ~decouple_q;
    active   = run | busy;
    bp_match = active & (event_cnt_q == breakpoint) & (breakpoint != BP_DISABLE);
    trigger  = (ti_req_r_q & ~ti_req_rr_q) | (bp_hit_q & ~bp_hit_dly_q);
    pr_rise  = pr_done_r_q & ~pr_done_rr_q;

    clk_ce_d = ({NUM_CLK_CH{run}} & ch_mask) | ({NUM_CLK_CH{busy}} & step_mask);

    // A matching cycle holds the count so the counter parks on the breakpoint.
    event_cnt_d = event_cnt_q;
    if (active && user_signal && !bp_hit_q && !bp_match)
      event_cnt_d = event_cnt_q + CNT_W'(1);

    bp_hit_d = bp_hit_q;
    if (bp_clear)      bp_hit_d = 1'b0;
    else if (bp_match) bp_hit_d = 1'b1;

    state_d    = state_q;
    stop_req_d = stop_req_q;
    decouple_d = decouple_q;
    case (state_q)
      IDLE: if (trigger) begin
        stop_req_d = '1;
        state_d    = REQ;
      end
      REQ: if (&stop_ack) begin
        decouple_d = 1'b1;
        state_d    = DEC;
      end
      DEC: if (pr_rise) begin
        decouple_d = 1'b0;
        stop_req_d = '0;
        state_d    = REL;
      end
      REL: if (~|stop_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      clk_en_r_q   <= 1'b0;
      ti_req_r_q   <= 1'b0;
      ti_req_rr_q  <= 1'b0;
      pr_done_r_q  <= 1'b0;
      pr_done_rr_q <= 1'b0;
      bp_hit_q     <= 1'b0;
      bp_hit_dly_q <= 1'b0;
      event_cnt_q  <= '0;
      clk_ce_q     <= '0;
      stop_req_q   <= '0;
      decouple_q   <= 1'b0;
      state_q      <= IDLE;
    end else begin
      clk_en_r_q   <= clk_en_r_d;
      ti_req_r_q   <= ti_req_r_d;
      ti_req_rr_q  <= ti_req_rr_d;
      pr_done_r_q  <= pr_done_r_d;
      pr_done_rr_q <= pr_done_rr_d;
      bp_hit_q     <= bp_hit_d;
      bp_hit_dly_q <= bp_hit_dly_d;
      event_cnt_q  <= event_cnt_d;
      clk_ce_q     <= clk_ce_d;
      stop_req_q   <= stop_req_d;
      decouple_q   <= decouple_d;
      state_q      <= state_d;
    end
  end

  assign clk_ce    = clk_ce_q;
  assign stop_req  = stop_req_q;
  assign decouple  = decouple_q;
  assign event_cnt = event_cnt_q;
  assign bp_hit    = bp_hit_q;
  assign step_busy = busy;
  assign ti_state  = state_q;

endmodule

// File: tb/tb_interruption_logic_mc.sv
// Bench for interruption_logic_mc: directed scenarios plus randomized traffic
// against a behavioural model of the enable/counter/handshake rules.
module tb_interruption_logic_mc;

  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic        sys_clk;
  logic        sys_reset_n;
  logic        clk_en, step_req, bp_clear, user_signal, ti_req, pr_done;
  logic [15:0] step_len;
  logic [1:0]  step_mask, ch_mask, stop_ack;
  logic [31:0] breakpoint;
  logic [1:0]  clk_ce, stop_req, ti_state;
  logic        decouple, bp_hit, step_busy;
  logic [31:0] event_cnt;

  logic [7:0]  bp_w;
  logic [1:0]  clk_ce_w, stop_req_w, ti_state_w;
  logic        decouple_w, bp_hit_w, step_busy_w;
  logic [7:0]  event_cnt_w;

  int n_checks, n_errors;

  interruption_logic_mc #(.NUM_TI_WRAPPERS(2), .NUM_CLK_CH(2), .CNT_W(32), .STEP_W(16)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .clk_en(clk_en), .step_req(step_req),
    .step_len(step_len), .step_mask(step_mask), .ch_mask(ch_mask), .breakpoint(breakpoint),
    .bp_clear(bp_clear), .user_signal(user_signal), .ti_req(ti_req), .pr_done(pr_done),
    .clk_ce(clk_ce), .stop_req(stop_req), .stop_ack(stop_ack), .decouple(decouple),
    .event_cnt(event_cnt), .bp_hit(bp_hit), .step_busy(step_busy), .ti_state(ti_state)
  );

  // Narrow-counter instance so the wrap boundary is reachable in simulation.
  interruption_logic_mc #(.NUM_TI_WRAPPERS(2), .NUM_CLK_CH(2), .CNT_W(8), .STEP_W(16)) dut_w (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .clk_en(clk_en), .step_req(step_req),
    .step_len(step_len), .step_mask(step_mask), .ch_mask(ch_mask), .breakpoint(bp_w),
    .bp_clear(bp_clear), .user_signal(user_signal), .ti_req(ti_req), .pr_done(pr_done),
    .clk_ce(clk_ce_w), .stop_req(stop_req_w), .stop_ack(stop_ack), .decouple(decouple_w),
    .event_cnt(event_cnt_w), .bp_hit(bp_hit_w), .step_busy(step_busy_w), .ti_state(ti_state_w)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference model: input histories, remaining burst cycles, phase number.
  logic        m_en_hist;
  logic [1:0]  m_sr_hist, m_ti_hist, m_pd_hist;
  int          m_left;
  logic [31:0] m_cnt;
  logic        m_bp, m_bp_prev, m_dec;
  logic [1:0]  m_ce, m_sreq, m_phase;
  logic        t_run, t_active, t_match, t_trig, t_pd_rise, t_sr_rise;

  always @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      m_en_hist = 0; m_sr_hist = 0; m_ti_hist = 0; m_pd_hist = 0;
      m_left = 0; m_cnt = 0; m_bp = 0; m_bp_prev = 0; m_dec = 0;
      m_ce = 0; m_sreq = 0; m_phase = 0;
    end else begin
      t_run     = m_en_hist && !m_bp && !m_dec;
      t_active  = t_run || (m_left > 0);
      t_match   = t_active && (m_cnt == breakpoint) && (breakpoint != ALL1);
      t_trig    = (m_ti_hist == 2'b01) || (m_bp && !m_bp_prev);
      t_pd_rise = (m_pd_hist == 2'b01);
      t_sr_rise = (m_sr_hist == 2'b01);
      for (int i = 0; i < 2; i++)
        m_ce[i] = (t_run && ch_mask[i]) || ((m_left > 0) && step_mask[i]);
      if (t_active && user_signal && !m_bp && !t_match) m_cnt = m_cnt + 1;
      m_bp_prev = m_bp;
      if (bp_clear) m_bp = 0;
      else if (t_match) m_bp = 1;
      if (m_left > 0) m_left = m_left - 1;
      else if (t_sr_rise && !m_dec) m_left = (step_len == 0) ? 1 : int'(step_len);
      case (m_phase)
        2'd0: if (t_trig) begin m_sreq = 2'b11; m_phase = 2'd1; end
        2'd1: if (stop_ack == 2'b11) begin m_dec = 1; m_phase = 2'd2; end
        2'd2: if (t_pd_rise) begin m_dec = 0; m_sreq = 2'b00; m_phase = 2'd3; end
        default: if (stop_ack == 2'b00) m_phase = 2'd0;
      endcase
      m_en_hist = clk_en;
      m_sr_hist = {m_sr_hist[0], step_req};
      m_ti_hist = {m_ti_hist[0], ti_req};
      m_pd_hist = {m_pd_hist[0], pr_done};
    end
  end

  task automatic quiesce();
    clk_en = 0; step_req = 0; step_len = 0; step_mask = 0; ch_mask = 0;
    breakpoint = ALL1; bp_clear = 0; user_signal = 0; ti_req = 0; pr_done = 0;
    stop_ack = 0; bp_w = 8'hFF;
  endtask

  task automatic do_reset();
    quiesce();
    sys_reset_n = 0;
    repeat (2) @(negedge sys_clk);
    sys_reset_n = 1;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (clk_ce !== 2'b00) begin n_errors++; $display("FAIL reset_clk_ce got %h want 0", clk_ce); end
    n_checks++; if (stop_req !== 2'b00) begin n_errors++; $display("FAIL reset_stop_req got %h want 0", stop_req); end
    n_checks++; if (decouple !== 1'b0) begin n_errors++; $display("FAIL reset_decouple got %b want 0", decouple); end
    n_checks++; if (event_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_event_cnt got %h want 0", event_cnt); end
    n_checks++; if (bp_hit !== 1'b0) begin n_errors++; $display("FAIL reset_bp_hit got %b want 0", bp_hit); end
    n_checks++; if (step_busy !== 1'b0) begin n_errors++; $display("FAIL reset_step_busy got %b want 0", step_busy); end
    n_checks++; if (ti_state !== 2'd0) begin n_errors++; $display("FAIL reset_ti_state got %0d want 0", ti_state); end
  endtask

  task automatic test_free_run();
    do_reset();
    ch_mask = 2'b01;
    clk_en = 1;
    @(negedge sys_clk);
    n_checks++; if (clk_ce !== 2'b00) begin n_errors++; $display("FAIL freerun_on_lat1 got %b want 00", clk_ce); end
    @(negedge sys_clk);
    n_checks++; if (clk_ce !== 2'b01) begin n_errors++; $display("FAIL freerun_on_lat2 got %b want 01", clk_ce); end
    repeat (3) @(negedge sys_clk);
    clk_en = 0;
    @(negedge sys_clk);
    n_checks++; if (clk_ce !== 2'b01) begin n_errors++; $display("FAIL freerun_off_lat1 got %b want 01", clk_ce); end
    @(negedge sys_clk);
    n_checks++; if (clk_ce !== 2'b00) begin n_errors++; $display("FAIL freerun_off_lat2 got %b want 00", clk_ce); end
  endtask

  task automatic run_burst(input logic [15:0] len, input int want, input bit retrigger);
    int ce_cnt, busy_cnt, first, last;
    do_reset();
    step_len = len; step_mask = 2'b11;
    ce_cnt = 0; busy_cnt = 0; first = -1; last = -1;
    step_req = 1;
    @(negedge sys_clk);
    step_req = 0;
    for (int i = 0; i < 16; i++) begin
      if (retrigger && i == 2) step_req = 1;
      if (retrigger && i == 3) step_req = 0;
      @(negedge sys_clk);
      if (clk_ce == 2'b11) begin
        ce_cnt++; last = i;
        if (first < 0) first = i;
      end
      if (step_busy) busy_cnt++;
    end
    n_checks++; if (ce_cnt != want) begin n_errors++; $display("FAIL burst_ce_len%0d got %0d want %0d", len, ce_cnt, want); end
    n_checks++; if (busy_cnt != want) begin n_errors++; $display("FAIL burst_busy_len%0d got %0d want %0d", len, busy_cnt, want); end
    n_checks++; if (last - first + 1 != want) begin n_errors++; $display("FAIL burst_contig_len%0d got %0d want %0d", len, last - first + 1, want); end
  endtask

  task automatic test_step_burst();
    run_burst(16'd5, 5, 1'b1);
    run_burst(16'd0, 1, 1'b0);
    run_burst(16'd3, 3, 1'b0);
  endtask

  task automatic test_breakpoint();
    int budget;
    do_reset();
    breakpoint = 32'd10; user_signal = 1; ch_mask = 2'b11; clk_en = 1;
    budget = 0;
    while (!bp_hit && budget < 40) begin @(negedge sys_clk); budget++; end
    n_checks++; if (!bp_hit) begin n_errors++; $display("FAIL bp_timeout got bp_hit=%b want 1", bp_hit); end
    n_checks++; if (event_cnt !== 32'd10) begin n_errors++; $display("FAIL bp_stop_cnt got %0d want 10", event_cnt); end
    repeat (3) @(negedge sys_clk);
    n_checks++; if (clk_ce !== 2'b00) begin n_errors++; $display("FAIL bp_clk_ce got %b want 00", clk_ce); end
    n_checks++; if (ti_state !== 2'd1) begin n_errors++; $display("FAIL bp_ti_state got %0d want 1", ti_state); end
    n_checks++; if (stop_req !== 2'b11) begin n_errors++; $display("FAIL bp_stop_req got %b want 11", stop_req); end
    n_checks++; if (event_cnt !== 32'd10) begin n_errors++; $display("FAIL bp_hold_cnt got %0d want 10", event_cnt); end
    bp_clear = 1;
    @(negedge sys_clk);
    bp_clear = 0;
    n_checks++; if (bp_hit !== 1'b0) begin n_errors++; $display("FAIL bp_clear_wins got %b want 0", bp_hit); end
    @(negedge sys_clk);
    n_checks++; if (bp_hit !== 1'b1) begin n_errors++; $display("FAIL bp_reset_on_match got %b want 1", bp_hit); end
    n_checks++; if (event_cnt !== 32'd10) begin n_errors++; $display("FAIL bp_rematch_cnt got %0d want 10", event_cnt); end
    bp_clear = 1; breakpoint = ALL1;
    @(negedge sys_clk);
    bp_clear = 0;
    n_checks++; if (bp_hit !== 1'b0 || event_cnt !== 32'd10) begin n_errors++; $display("FAIL bp_cleared got hit=%b cnt=%0d want 0/10", bp_hit, event_cnt); end
    @(negedge sys_clk);
    n_checks++; if (event_cnt !== 32'd11) begin n_errors++; $display("FAIL bp_resume got %0d want 11", event_cnt); end
  endtask

  task automatic test_ti_handshake();
    do_reset();
    clk_en = 1; ch_mask = 2'b11;
    ti_req = 1;
    repeat (2) @(negedge sys_clk);
    ti_req = 0;
    n_checks++; if (ti_state !== 2'd1 || stop_req !== 2'b11) begin n_errors++; $display("FAIL ti_req got state=%0d stop_req=%b want 1/11", ti_state, stop_req); end
    stop_ack = 2'b01; pr_done = 1;
    repeat (2) @(negedge sys_clk);
    pr_done = 0;
    repeat (2) @(negedge sys_clk);
    n_checks++; if (ti_state !== 2'd1 || decouple !== 1'b0) begin n_errors++; $display("FAIL ti_partial_ack got state=%0d dec=%b want 1/0", ti_state, decouple); end
    stop_ack = 2'b11;
    @(negedge sys_clk);
    n_checks++; if (ti_state !== 2'd2 || decouple !== 1'b1) begin n_errors++; $display("FAIL ti_dec got state=%0d dec=%b want 2/1", ti_state, decouple); end
    n_checks++; if (clk_ce !== 2'b11) begin n_errors++; $display("FAIL ti_ce_before_gate got %b want 11", clk_ce); end
    @(negedge sys_clk);
    n_checks++; if (clk_ce !== 2'b00) begin n_errors++; $display("FAIL ti_ce_gated got %b want 00", clk_ce); end
    pr_done = 1;
    @(negedge sys_clk);
    n_checks++; if (ti_state !== 2'd2) begin n_errors++; $display("FAIL ti_pr_lat got state=%0d want 2", ti_state); end
    @(negedge sys_clk);
    n_checks++; if (ti_state !== 2'd3 || decouple !== 1'b0 || stop_req !== 2'b00) begin n_errors++; $display("FAIL ti_rel got state=%0d dec=%b stop_req=%b want 3/0/00", ti_state, decouple, stop_req); end
    repeat (2) @(negedge sys_clk);
    n_checks++; if (ti_state !== 2'd3) begin n_errors++; $display("FAIL ti_rel_hold got state=%0d want 3", ti_state); end
    stop_ack = 2'b00;
    @(negedge sys_clk);
    n_checks++; if (ti_state !== 2'd0) begin n_errors++; $display("FAIL ti_idle got state=%0d want 0", ti_state); end
    pr_done = 0;
  endtask

  task automatic test_wrap();
    int budget;
    do_reset();
    clk_en = 1; user_signal = 1;
    budget = 0;
    while (event_cnt_w !== 8'hFF && budget < 300) begin @(negedge sys_clk); budget++; end
    n_checks++; if (event_cnt_w !== 8'hFF) begin n_errors++; $display("FAIL wrap_timeout got %h want FF", event_cnt_w); end
    @(negedge sys_clk);
    n_checks++; if (event_cnt_w !== 8'h00) begin n_errors++; $display("FAIL wrap_value got %h want 00", event_cnt_w); end
    n_checks++; if (bp_hit_w !== 1'b0) begin n_errors++; $display("FAIL wrap_bp_hit got %b want 0", bp_hit_w); end
    n_checks++; if (event_cnt !== 32'h100) begin n_errors++; $display("FAIL wide_cnt got %h want 100", event_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    clk_en = 1; user_signal = 1; ch_mask = 2'b11; ti_req = 1; stop_ack = 2'b11;
    repeat (6) @(negedge sys_clk);
    n_checks++; if (ti_state !== 2'd2 || decouple !== 1'b1) begin n_errors++; $display("FAIL ar_pre got state=%0d dec=%b want 2/1", ti_state, decouple); end
    n_checks++; if (event_cnt == 32'd0) begin n_errors++; $display("FAIL ar_pre_cnt got %0d want nonzero", event_cnt); end
    #2 sys_reset_n = 0;
    #1;
    n_checks++; if (decouple !== 1'b0 || stop_req !== 2'b00 || clk_ce !== 2'b00 || event_cnt !== 32'd0)
      begin n_errors++; $display("FAIL ar_immediate got dec=%b sreq=%b ce=%b cnt=%0d want all 0", decouple, stop_req, clk_ce, event_cnt); end
    quiesce();
    @(negedge sys_clk);
    sys_reset_n = 1;
    @(negedge sys_clk);
    n_checks++; if (ti_state !== 2'd0 || stop_req !== 2'b00 || decouple !== 1'b0) begin n_errors++; $display("FAIL ar_release got state=%0d sreq=%b dec=%b want 0/00/0", ti_state, stop_req, decouple); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) clk_en = ~clk_en;
      if ($urandom_range(0, 5) == 0) step_req = ~step_req;
      step_len  = 16'($urandom_range(0, 6));
      step_mask = 2'($urandom_range(0, 3));
      ch_mask   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0)
        breakpoint = ($urandom_range(0, 2) == 0) ? ALL1 : m_cnt + 32'($urandom_range(0, 8));
      bp_clear    = ($urandom_range(0, 15) == 0);
      user_signal = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ti_req = ~ti_req;
      if ($urandom_range(0, 5) == 0) pr_done = ~pr_done;
      if ($urandom_range(0, 3) == 0) stop_ack = 2'($urandom_range(0, 3));
      @(negedge sys_clk);
      n_checks++; if (clk_ce !== m_ce) begin n_errors++; $display("FAIL rnd_clk_ce cyc %0d got %b want %b", c, clk_ce, m_ce); end
      n_checks++; if (event_cnt !== m_cnt) begin n_errors++; $display("FAIL rnd_event_cnt cyc %0d got %0d want %0d", c, event_cnt, m_cnt); end
      n_checks++; if (bp_hit !== m_bp) begin n_errors++; $display("FAIL rnd_bp_hit cyc %0d got %b want %b", c, bp_hit, m_bp); end
      n_checks++; if (step_busy !== (m_left > 0)) begin n_errors++; $display("FAIL rnd_step_busy cyc %0d got %b want %b", c, step_busy, m_left > 0); end
      n_checks++; if (ti_state !== m_phase) begin n_errors++; $display("FAIL rnd_ti_state cyc %0d got %0d want %0d", c, ti_state, m_phase); end
      n_checks++; if (stop_req !== m_sreq) begin n_errors++; $display("FAIL rnd_stop_req cyc %0d got %b want %b", c, stop_req, m_sreq); end
      n_checks++; if (decouple !== m_dec) begin n_errors++; $display("FAIL rnd_decouple cyc %0d got %b want %b", c, decouple, m_dec); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    quiesce();
    sys_reset_n = 0;
    test_reset();
    test_free_run();
    test_step_burst();
    test_breakpoint();
    test_ti_handshake();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
